// File: rtl/ex_stage.sv
// Execute stage: single-cycle logic/shift/arith ops plus a 32-step restoring
// radix-2 divider that stalls the front of the pipeline until its result is ready.
module ex_stage #(
  parameter int ALUSEL_W = 3,
  parameter int ALUOP_W  = 8,
  parameter int DATA_W   = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic [ALUSEL_W-1:0] ex_alusel,
  input  logic [ALUOP_W-1:0]  ex_aluop,
  input  logic [DATA_W-1:0]   ex_reg1,
  input  logic [DATA_W-1:0]   ex_reg2,
  input  logic [4:0]          ex_reg_write_addr,
  input  logic                ex_reg_write_en,
  output logic [DATA_W-1:0]   ex_result,
  output logic [4:0]          ex_out_write_addr,
  output logic                ex_out_write_en,
  output logic                stall_req
);

  localparam logic [ALUSEL_W-1:0] SEL_LOGIC = ALUSEL_W'(1);
  localparam logic [ALUSEL_W-1:0] SEL_SHIFT = ALUSEL_W'(2);
  localparam logic [ALUSEL_W-1:0] SEL_ARITH = ALUSEL_W'(3);
  localparam logic [ALUSEL_W-1:0] SEL_DIV   = ALUSEL_W'(4);

  localparam logic [ALUOP_W-1:0] OP_ADD  = ALUOP_W'(8'h01);
  localparam logic [ALUOP_W-1:0] OP_SUB  = ALUOP_W'(8'h02);
  localparam logic [ALUOP_W-1:0] OP_SLT  = ALUOP_W'(8'h03);
  localparam logic [ALUOP_W-1:0] OP_SLTU = ALUOP_W'(8'h04);
  localparam logic [ALUOP_W-1:0] OP_AND  = ALUOP_W'(8'h05);
  localparam logic [ALUOP_W-1:0] OP_OR   = ALUOP_W'(8'h06);
  localparam logic [ALUOP_W-1:0] OP_XOR  = ALUOP_W'(8'h07);
  localparam logic [ALUOP_W-1:0] OP_NOR  = ALUOP_W'(8'h08);
  localparam logic [ALUOP_W-1:0] OP_SLL  = ALUOP_W'(8'h09);
  localparam logic [ALUOP_W-1:0] OP_SRL  = ALUOP_W'(8'h0A);
  localparam logic [ALUOP_W-1:0] OP_SRA  = ALUOP_W'(8'h0B);
  localparam logic [ALUOP_W-1:0] OP_DIV  = ALUOP_W'(8'h10);
  localparam logic [ALUOP_W-1:0] OP_MOD  = ALUOP_W'(8'h11);
  localparam logic [ALUOP_W-1:0] OP_DIVU = ALUOP_W'(8'h12);
  localparam logic [ALUOP_W-1:0] OP_MODU = ALUOP_W'(8'h13);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  function automatic logic [DATA_W-1:0] f_neg_if(input logic [DATA_W-1:0] v,
                                                 input logic            neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [DATA_W-1:0] f_abs(input logic [DATA_W-1:0] v,
                                              input logic            is_signed);
    return f_neg_if(v, is_signed & v[DATA_W-1]);
  endfunction

  state_t              r_state;
  state_t              w_state_nxt;
  logic [DATA_W-1:0]   r_dvd;
  logic [DATA_W-1:0]   r_dvs;
  logic [DATA_W:0]     r_rem;
  logic [4:0]          r_cnt;
  logic                r_q_neg;
  logic                r_r_neg;
  logic                r_mod;
  logic                r_dvz;

  logic signed [DATA_W-1:0] w_a_s;
  logic signed [DATA_W-1:0] w_b_s;
  logic signed [DATA_W-1:0] w_sra;
  logic [4:0]          w_shamt;
  logic [DATA_W-1:0]   w_alu_res;
  logic                w_alu_ok;
  logic                w_div_op_ok;
  logic                w_div_start;
  logic                w_div_sgn;
  logic                w_div_mod;
  logic [DATA_W+1:0]   w_rem_sh;
  logic [DATA_W+1:0]   w_diff;
  logic                w_ge;
  logic [DATA_W-1:0]   w_quo;
  logic [DATA_W-1:0]   w_remv;
  logic [DATA_W-1:0]   w_div_res;
  logic [DATA_W-1:0]   w_result;
  logic                w_wen;
  logic                w_stall;

  assign w_a_s   = ex_reg1;
  assign w_b_s   = ex_reg2;
  assign w_shamt = ex_reg2[4:0];
  assign w_sra   = w_a_s >>> w_shamt;

  always_comb begin
    w_alu_res = '0;
    w_alu_ok  = 1'b1;
    case (ex_alusel)
      SEL_LOGIC: begin
        case (ex_aluop)
          OP_AND:  w_alu_res = ex_reg1 & ex_reg2;
          OP_OR:   w_alu_res = ex_reg1 | ex_reg2;
          OP_XOR:  w_alu_res = ex_reg1 ^ ex_reg2;
          OP_NOR:  w_alu_res = ~(ex_reg1 | ex_reg2);
          default: w_alu_ok  = 1'b0;
        endcase
      end
      SEL_SHIFT: begin
        case (ex_aluop)
          OP_SLL:  w_alu_res = ex_reg1 << w_shamt;
          OP_SRL:  w_alu_res = ex_reg1 >> w_shamt;
          OP_SRA:  w_alu_res = w_sra;
          default: w_alu_ok  = 1'b0;
        endcase
      end
      SEL_ARITH: begin
        case (ex_aluop)
          OP_ADD:  w_alu_res = ex_reg1 + ex_reg2;
          OP_SUB:  w_alu_res = ex_reg1 - ex_reg2;
          OP_SLT:  w_alu_res = DATA_W'(w_a_s < w_b_s);
          OP_SLTU: w_alu_res = DATA_W'(ex_reg1 < ex_reg2);
          default: w_alu_ok  = 1'b0;
        endcase
      end
      default: w_alu_ok = 1'b0;
    endcase
  end

  assign w_div_op_ok = (ex_aluop >= OP_DIV) && (ex_aluop <= OP_MODU);
  assign w_div_start = (r_state == S_IDLE) && (ex_alusel == SEL_DIV) && w_div_op_ok && !flush;
  assign w_div_sgn   = (ex_aluop == OP_DIV) || (ex_aluop == OP_MOD);
  assign w_div_mod   = (ex_aluop == OP_MOD) || (ex_aluop == OP_MODU);

  // Restoring step: the extra top bit of the shifted remainder keeps the borrow visible.
  assign w_rem_sh = {r_rem, r_dvd[DATA_W-1]};
  assign w_diff   = w_rem_sh - {2'b00, r_dvs};
  assign w_ge     = ~w_diff[DATA_W+1];

  assign w_quo     = r_dvz ? '1 : f_neg_if(r_dvd, r_q_neg);
  assign w_remv    = f_neg_if(r_rem[DATA_W-1:0], r_r_neg);
  assign w_div_res = r_mod ? w_remv : w_quo;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_dvd   <= '0;
      r_dvs   <= '0;
      r_rem   <= '0;
      r_cnt   <= '0;
      r_q_neg <= 1'b0;
      r_r_neg <= 1'b0;
      r_mod   <= 1'b0;
      r_dvz   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_div_start) begin
        r_dvd   <= f_abs(ex_reg1, w_div_sgn);
        r_dvs   <= f_abs(ex_reg2, w_div_sgn);
        r_q_neg <= w_div_sgn & (ex_reg1[DATA_W-1] ^ ex_reg2[DATA_W-1]);
        r_r_neg <= w_div_sgn & ex_reg1[DATA_W-1];
        r_mod   <= w_div_mod;
        r_dvz   <= (ex_reg2 == '0);
        r_rem   <= '0;
        r_cnt   <= '0;
      end else if (r_state == S_BUSY) begin
        r_rem <= w_ge ? w_diff[DATA_W:0] : w_rem_sh[DATA_W:0];
        r_dvd <= {r_dvd[DATA_W-2:0], w_ge};
        r_cnt <= r_cnt + 5'd1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_div_start) w_state_nxt = S_BUSY;
      S_BUSY: begin
        if (flush)               w_state_nxt = S_IDLE;
        else if (r_cnt == 5'd31) w_state_nxt = S_DONE;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_result = '0;
    w_wen    = 1'b0;
    w_stall  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_div_start) begin
          w_stall = 1'b1;
        end else begin
          w_result = w_alu_res;
          w_wen    = w_alu_ok & ex_reg_write_en;
        end
      end
      S_BUSY: w_stall = 1'b1;
      S_DONE: begin
        w_result = w_div_res;
        w_wen    = ex_reg_write_en;
      end
      default: ;
    endcase
    if (flush) begin
      w_wen   = 1'b0;
      w_stall = 1'b0;
    end
    // Reset blanks every output immediately, not just at the next edge.
    if (!rst) begin
      w_result = '0;
      w_wen    = 1'b0;
      w_stall  = 1'b0;
    end
  end

  assign ex_result         = w_result;
  assign ex_out_write_en   = w_wen;
  assign stall_req         = w_stall;
  assign ex_out_write_addr = rst ? ex_reg_write_addr : 5'd0;

endmodule
